run_detect_fsm: RTL and testbench

- Parametrised Moore-type run detector: watches serial input w and flags when N consecutive sampled bits equal a selectable polarity.
- Generalises the fixed "two consecutive 1s" detector with:
  - run length N;
  - ones/zeros polarity select;
  - saturating vs non-overlapping detection mode;
  - a clock enable;
  - a detection pulse and a detection counter.
- Used as a reusable front-end for serial-pattern and debounce logic in lab designs.

---
 rtl/run_detect_fsm_if.sv | 29 ++
 rtl/run_detect_fsm.sv | 80 ++++++++
 tb/tb_run_detect_fsm.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/run_detect_fsm_if.sv
// Signal bundle for run_detect_fsm: sample controls in, detect status out.
// The master drives the controls; the slave is the detector itself.
interface run_detect_fsm_if #(
    parameter int unsigned N     = 2,
    parameter int unsigned CNT_W = 8
);
    localparam int unsigned RW = $clog2(N + 1);

    logic             en;
    logic             w;
    logic             pol;
    logic             mode;
    logic             clr_cnt;
    logic             z;
    logic             hit;
    logic [RW-1:0]    run_len;
    logic [CNT_W-1:0] det_count;
    logic             ovf;

    modport master (
        output en, w, pol, mode, clr_cnt,
        input  z, hit, run_len, det_count, ovf
    );

    modport slave (
        input  en, w, pol, mode, clr_cnt,
        output z, hit, run_len, det_count, ovf
    );
endinterface

// File: rtl/run_detect_fsm.sv
// Moore run detector: flags N consecutive sampled bits equal to pol, with a
// one-cycle hit pulse and a wrapping detection counter with sticky overflow.
module run_detect_fsm #(
    parameter int unsigned N     = 2,
    parameter int unsigned CNT_W = 8
) (
    input logic              Clock,
    input logic              Reset,
    run_detect_fsm_if.slave  bus
);
    localparam int unsigned RW = $clog2(N + 1);
    localparam logic [RW-1:0] RunMax = RW'(N);
    localparam logic [RW-1:0] RunOne = RW'(1);

    typedef enum logic [1:0] {StIdle, StRun, StDet} state_e;

    state_e           state;
    logic             match;
    logic [RW-1:0]    run_q, run_d;
    logic             hit_q, hit_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    // State is carried entirely by the run counter.
    always_comb begin
        if (run_q == '0) begin
            state = StIdle;
        end else if (run_q == RunMax) begin
            state = StDet;
        end else begin
            state = StRun;
        end
    end

    always_comb begin
        run_d = run_q;
        hit_d = 1'b0;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        match = (bus.w == bus.pol);
        if (bus.en) begin
            unique case (state)
                StIdle, StRun: run_d = match ? run_q + 1'b1 : '0;
                StDet:         run_d = !match ? '0 : (bus.mode ? RunOne : RunMax);
                default:       run_d = '0;
            endcase
            // Re-entry from DET (mode=1, N=1) counts as a fresh detection.
            hit_d = (run_d == RunMax) && ((state != StDet) || bus.mode);
            if (bus.clr_cnt) begin
                cnt_d = '0;
                ovf_d = 1'b0;
            end else if (hit_d) begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == '1) begin
                    ovf_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            run_q <= '0;
            hit_q <= 1'b0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            run_q <= run_d;
            hit_q <= hit_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign bus.z         = (state == StDet);
    assign bus.hit       = hit_q;
    assign bus.run_len   = run_q;
    assign bus.det_count = cnt_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_run_detect_fsm.sv
// Drives four differently-sized detectors with shared stimulus and compares each
// against a behavioural run/hit/counter model every cycle.
module tb_run_detect_fsm;
    logic clk, rst, en, w, pol, mode, clr;
    int checks = 0;
    int failures = 0;

    int nv[4] = '{3, 1, 2, 4};
    int cw[4] = '{8, 2, 8, 3};

    int mr[4], mcnt[4];
    bit mhit[4], movf[4];

    logic [31:0] o_r[4], o_cnt[4];
    logic        o_z[4], o_hit[4], o_ovf[4];

    run_detect_fsm_if #(.N(3), .CNT_W(8)) if0 ();
    run_detect_fsm_if #(.N(1), .CNT_W(2)) if1 ();
    run_detect_fsm_if #(.N(2), .CNT_W(8)) if2 ();
    run_detect_fsm_if #(.N(4), .CNT_W(3)) if3 ();

    run_detect_fsm #(.N(3), .CNT_W(8)) u0 (.Clock(clk), .Reset(rst), .bus(if0.slave));
    run_detect_fsm #(.N(1), .CNT_W(2)) u1 (.Clock(clk), .Reset(rst), .bus(if1.slave));
    run_detect_fsm #(.N(2), .CNT_W(8)) u2 (.Clock(clk), .Reset(rst), .bus(if2.slave));
    run_detect_fsm #(.N(4), .CNT_W(3)) u3 (.Clock(clk), .Reset(rst), .bus(if3.slave));

    assign if0.en = en; assign if0.w = w; assign if0.pol = pol;
    assign if0.mode = mode; assign if0.clr_cnt = clr;
    assign if1.en = en; assign if1.w = w; assign if1.pol = pol;
    assign if1.mode = mode; assign if1.clr_cnt = clr;
    assign if2.en = en; assign if2.w = w; assign if2.pol = pol;
    assign if2.mode = mode; assign if2.clr_cnt = clr;
    assign if3.en = en; assign if3.w = w; assign if3.pol = pol;
    assign if3.mode = mode; assign if3.clr_cnt = clr;

    assign o_r[0] = 32'(if0.run_len); assign o_cnt[0] = 32'(if0.det_count);
    assign o_r[1] = 32'(if1.run_len); assign o_cnt[1] = 32'(if1.det_count);
    assign o_r[2] = 32'(if2.run_len); assign o_cnt[2] = 32'(if2.det_count);
    assign o_r[3] = 32'(if3.run_len); assign o_cnt[3] = 32'(if3.det_count);
    assign o_z[0] = if0.z; assign o_hit[0] = if0.hit; assign o_ovf[0] = if0.ovf;
    assign o_z[1] = if1.z; assign o_hit[1] = if1.hit; assign o_ovf[1] = if1.ovf;
    assign o_z[2] = if2.z; assign o_hit[2] = if2.hit; assign o_ovf[2] = if2.ovf;
    assign o_z[3] = if3.z; assign o_hit[3] = if3.hit; assign o_ovf[3] = if3.ovf;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s obs=%0d exp=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Streak of matching samples; a full streak either saturates or restarts at one.
    task automatic model_edge(input int k);
        int n, rn;
        bit h;
        n = nv[k];
        if (rst) begin
            mr[k] = 0; mhit[k] = 0; mcnt[k] = 0; movf[k] = 0;
        end else if (en) begin
            if (w != pol)       rn = 0;
            else if (mr[k] < n) rn = mr[k] + 1;
            else                rn = mode ? 1 : n;
            h = (rn == n) && (mr[k] != n || mode);
            if (clr) begin
                mcnt[k] = 0; movf[k] = 0;
            end else if (h) begin
                mcnt[k] = mcnt[k] + 1;
                if (mcnt[k] == (1 << cw[k])) begin
                    mcnt[k] = 0; movf[k] = 1;
                end
            end
            mr[k] = rn;
            mhit[k] = h;
        end else begin
            mhit[k] = 0;
        end
    endtask

    task automatic step(input bit r_, input bit e_, input bit w_, input bit p_,
                        input bit m_, input bit c_);
        rst = r_; en = e_; w = w_; pol = p_; mode = m_; clr = c_;
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            model_edge(k);
            check($sformatf("run_len[N=%0d]", nv[k]), o_r[k], 32'(mr[k]));
            check($sformatf("z[N=%0d]", nv[k]), 32'(o_z[k]), 32'(mr[k] == nv[k]));
            check($sformatf("hit[N=%0d]", nv[k]), 32'(o_hit[k]), 32'(mhit[k]));
            check($sformatf("det_count[N=%0d]", nv[k]), o_cnt[k], 32'(mcnt[k]));
            check($sformatf("ovf[N=%0d]", nv[k]), 32'(o_ovf[k]), 32'(movf[k]));
        end
    endtask

    bit w_sat[6]   = '{0, 1, 1, 1, 1, 0};
    int r_sat[6]   = '{0, 1, 2, 3, 3, 0};
    bit w_non[5]   = '{0, 0, 0, 0, 1};
    int r_non[5]   = '{1, 2, 1, 2, 0};
    bit en_gate[5] = '{1, 0, 0, 1, 1};
    int r_gate[5]  = '{1, 1, 1, 2, 3};
    int c_wrap[4]  = '{1, 2, 3, 0};

    initial begin
        int zc, hc;
        bit zprev, zpair;
        bit rp, rm;
        rst = 1'b1; en = 1'b1; w = 1'b1; pol = 1'b1; mode = 1'b0; clr = 1'b0;

        // Reset with w=1, en=1 for two cycles.
        step(1, 1, 1, 1, 0, 0);
        step(1, 1, 1, 1, 0, 0);
        check("rst_z", 32'(o_z[0]), 0);
        check("rst_cnt", o_cnt[0], 0);

        // Saturating, N=3.
        zc = 0; hc = 0;
        for (int i = 0; i < 6; i++) begin
            step(0, 1, w_sat[i], 1, 0, 0);
            check("sat_run_len", o_r[0], 32'(r_sat[i]));
            zc += int'(o_z[0]); hc += int'(o_hit[0]);
        end
        check("sat_z_cycles", 32'(zc), 2);
        check("sat_hits", 32'(hc), 1);
        check("sat_det_count", o_cnt[0], 1);

        // Non-overlapping zeros, N=2.
        step(1, 1, 0, 0, 1, 0);
        hc = 0; zprev = 0; zpair = 0;
        for (int i = 0; i < 5; i++) begin
            step(0, 1, w_non[i], 0, 1, 0);
            check("non_run_len", o_r[2], 32'(r_non[i]));
            hc += int'(o_hit[2]);
            if (zprev && o_z[2]) zpair = 1;
            zprev = o_z[2];
        end
        check("non_hits", 32'(hc), 2);
        check("non_det_count", o_cnt[2], 2);
        check("non_z_pair", 32'(zpair), 0);

        // Enable gating, N=3.
        step(1, 1, 0, 1, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step(0, en_gate[i], 1, 1, 0, 0);
            check("gate_run_len", o_r[0], 32'(r_gate[i]));
            check("gate_z", 32'(o_z[0]), 32'(i == 4));
        end

        // Counter wrap and clear, N=1 CNT_W=2.
        step(1, 1, 0, 1, 1, 0);
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 1, 1, 1, 0);
            check("wrap_cnt", o_cnt[1], 32'(c_wrap[i]));
            check("wrap_hit", 32'(o_hit[1]), 1);
        end
        check("wrap_ovf", 32'(o_ovf[1]), 1);
        step(0, 1, 1, 1, 1, 1);
        check("clr_cnt", o_cnt[1], 0);
        check("clr_ovf", 32'(o_ovf[1]), 0);
        check("clr_hit", 32'(o_hit[1]), 1);

        // Reset mid-run, N=4.
        step(1, 1, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 1, 1, 0, 0);
        check("mid_run_len", o_r[3], 3);
        step(1, 1, 1, 1, 0, 0);
        check("mid_rst_run_len", o_r[3], 0);
        for (int i = 0; i < 4; i++) begin
            step(0, 1, 1, 1, 0, 0);
            check("mid_z", 32'(o_z[3]), 32'(i == 3));
        end

        // Randomised traffic biased toward long runs.
        rp = 1; rm = 0;
        for (int i = 0; i < 4000; i++) begin
            bit e, ww, c, r;
            if ($urandom_range(0, 49) == 0) rp = ~rp;
            if ($urandom_range(0, 29) == 0) rm = ~rm;
            e  = ($urandom_range(0, 3) != 0);
            ww = ($urandom_range(0, 5) != 0) ? rp : ~rp;
            c  = e && ($urandom_range(0, 39) == 0);
            r  = ($urandom_range(0, 199) == 0);
            step(r, e, ww, rp, rm, c);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
